cp0: RTL and testbench

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline; it consumes the exception codes produced upstream (notably ALU `Overflow`, ExcCode 12) and the external hardware interrupt lines. It sits beside the M stage: it raises a flush/redirect request, latches the victim PC into EPC, and serves `mfc0`/`mtc0`/`eret`. State is held in SR, Cause, EPC and a constant PRId.

---
 rtl/cp0.sv | 116 +++++++++++
 tb/tb_cp0.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt controller beside the M stage.
// Holds SR, Cause, EPC and a constant PRId. Raises Req (combinational) when an
// enabled interrupt or an M-stage exception is pending and no handler is
// active, records the victim PC/cause on the following edge, and serves
// mfc0 (DOut), mtc0 (WE/A2/DIn) and eret (EXLClr).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   A1               mfc0 read register number -> DOut (combinational)
//   A2, DIn, WE      mtc0 write address, data, enable
//   PC, BDIn         victim PC and branch-delay-slot flag
//   ExcCodeIn        M-stage exception code, 0 = none
//   HWInt            level-sensitive hardware interrupt lines
//   EXLClr           eret in M stage
//   Req              exception/interrupt taken this cycle (combinational)
//   EPCOut           current EPC register
module cp0 #(
    parameter logic [31:0] PRID = 32'h2021_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned CODE_W = 5;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Architectural state; only the implemented bits are stored.
    logic [INT_W-1:0]  sr_im;
    logic              sr_exl;
    logic              sr_ie;
    logic              cause_bd;
    logic [INT_W-1:0]  cause_ip;
    logic [CODE_W-1:0] cause_exc;
    logic [XLEN-1:2]   epc;

    logic              int_req;
    logic              exc_req;
    logic [XLEN-1:0]   victim_pc;
    logic              unused_pc_lsb;

    // Request generation: interrupts use HWInt directly, not the lagging IP.
    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (ExcCodeIn != CODE_W'(0)) & ~sr_exl;
    assign Req     = int_req | exc_req;

    // Delay-slot victims restart at the branch; wraps modulo 2^32.
    assign victim_pc     = BDIn ? (PC - XLEN'(4)) : PC;
    assign unused_pc_lsb = ^victim_pc[1:0];

    // State update: reset > Req > EXLClr > mtc0 write of EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? CODE_W'(0) : ExcCodeIn;
                cause_bd  <= BDIn;
                epc       <= victim_pc[XLEN-1:2];
            end else begin
                if (WE && (A2 == REG_SR)) begin
                    sr_im <= DIn[15:10];
                    sr_ie <= DIn[0];
                end
                // eret overrides a same-cycle mtc0 write of EXL only.
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end else if (WE && (A2 == REG_SR)) begin
                    sr_exl <= DIn[1];
                end
                if (WE && (A2 == REG_EPC)) begin
                    epc <= DIn[XLEN-1:2];
                end
            end
        end
    end

    assign EPCOut = {epc, 2'b00};

    // mfc0 read port; no bypass of a same-cycle mtc0.
    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            REG_CAUSE: DOut = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};
            REG_EPC:   DOut = {epc, 2'b00};
            REG_PRID:  DOut = PRID;
            default:   DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Testbench for cp0: a table of per-cycle {inputs, expected outputs} vectors.
// Each vector's expectation is pushed to a scoreboard queue when its inputs
// are driven and popped and compared once the outputs have settled.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h2021_0007;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    cp0 #(.PRID(PRID)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC        (PC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .Req       (Req),
        .EPCOut    (EPCOut),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] din, input logic we, input logic [31:0] pc,
                                input logic bd, input logic [4:0] exc, input logic [5:0] hw,
                                input logic clr, input logic req, input logic [31:0] dout,
                                input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc;
        v.bd = bd; v.exc = exc; v.hw = hw; v.clr = clr;
        v.req = req; v.dout = dout; v.epc = epc;
        return v;
    endfunction

    task automatic check32(input string name, input int idx, input logic [31:0] act,
                           input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Fields: rst a1 a2 din we pc bd exc hw clr | req dout epc
        // Reset state reads, IP lag, Req masked with IE=0.
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 15, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, PRID, 32'h0));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h3F, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0000_FC00, 32'h0));
        // Overflow exception, then suppressed second exception while EXL.
        vecs.push_back(mk(0, 13, 0, 0, 0, 32'h3010, 0, 12, 6'h00, 0, 1, 32'h0, 32'h0));
        vecs.push_back(mk(0, 13, 0, 0, 0, 32'h4000, 0, 12, 6'h00, 0, 0, 32'h30, 32'h3010));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h2, 32'h3010));
        vecs.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h3010, 32'h3010));
        // eret clears EXL.
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 1, 0, 32'h2, 32'h3010));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h3010));
        // mtc0 SR (no bypass), then interrupt beats exception in delay slot.
        vecs.push_back(mk(0, 12, 12, 32'h401, 1, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h3010));
        vecs.push_back(mk(0, 12, 0, 0, 0, 32'h3008, 1, 12, 6'h01, 0, 1, 32'h401, 32'h3010));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h01, 0, 0, 32'h8000_0400, 32'h3004));
        // eret with interrupt still pending -> Req the following cycle.
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h01, 1, 0, 32'h403, 32'h3004));
        vecs.push_back(mk(0, 12, 0, 0, 0, 32'h5000, 0, 0, 6'h01, 0, 1, 32'h401, 32'h3004));
        vecs.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h5000, 32'h5000));
        // mtc0 EPC truncates low bits.
        vecs.push_back(mk(0, 14, 14, 32'h3057, 1, 0, 0, 0, 6'h00, 0, 0, 32'h5000, 32'h5000));
        vecs.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h3054, 32'h3054));
        // Clear EXL via mtc0, then mtc0 EPC loses to Req.
        vecs.push_back(mk(0, 12, 12, 32'h401, 1, 0, 0, 0, 6'h00, 0, 0, 32'h403, 32'h3054));
        vecs.push_back(mk(0, 14, 14, 32'h1234_5678, 1, 32'h6000, 0, 12, 6'h00, 0, 1, 32'h3054, 32'h3054));
        vecs.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h6000, 32'h6000));
        // eret + mtc0 SR same cycle: EXL cleared, IM/IE written.
        vecs.push_back(mk(0, 12, 12, 32'h803, 1, 0, 0, 0, 6'h00, 1, 0, 32'h403, 32'h6000));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h01, 0, 0, 32'h801, 32'h6000));
        // Interrupt on line 1 from PC 0 in delay slot -> EPC wraps.
        vecs.push_back(mk(0, 12, 0, 0, 0, 32'h0, 1, 0, 6'h02, 0, 1, 32'h801, 32'h6000));
        vecs.push_back(mk(0, 14, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h8000_0000, 32'hFFFF_FFFC));
        // Reset mid-handler.
        vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h803, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        // Writes to Cause, PRId and unmapped registers are ignored.
        vecs.push_back(mk(0, 13, 13, 32'hFFFF_FFFF, 1, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 13, 15, 32'hFFFF_FFFF, 1, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 15, 3, 32'hFFFF_FFFF, 1, 0, 0, 0, 6'h00, 0, 0, PRID, 32'h0));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        // Reset beats a same-cycle exception.
        vecs.push_back(mk(1, 14, 0, 0, 0, 32'h7000, 0, 12, 6'h00, 0, 1, 32'h0, 32'h0));
        vecs.push_back(mk(0, 12, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0, 32'h0));

        reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; WE = 1'b0; PC = '0;
        BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            reset = vecs[i].rst; A1 = vecs[i].a1; A2 = vecs[i].a2; DIn = vecs[i].din;
            WE = vecs[i].we; PC = vecs[i].pc; BDIn = vecs[i].bd;
            ExcCodeIn = vecs[i].exc; HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
            e.idx = i; e.req = vecs[i].req; e.dout = vecs[i].dout; e.epc = vecs[i].epc;
            sb.push_back(e);
            #2;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard vec%0d: queue empty", i);
            end else begin
                exp_t g;
                g = sb.pop_front();
                check32("Req", g.idx, {31'b0, Req}, {31'b0, g.req});
                check32("DOut", g.idx, DOut, g.dout);
                check32("EPCOut", g.idx, EPCOut, g.epc);
            end
            @(posedge clk);
            #1;
        end

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
